led_panel_scanner: RTL

Refresh controller for the 24-bit RGB frame memory: continuously reads pixels through the memory's read port B and drives a HUB75-style LED panel using binary-code modulation (BCM) with 8 bit-planes per channel. It owns port B, while port A stays free for host or CPU writes. It sits between the frame memory and the panel connector pins.

---
 rtl/panel_pkg.sv | 16 +
 rtl/bcm_timer.sv | 27 ++
 rtl/led_panel_scanner.sv | 111 +++++++++++
 3 files changed

// File: rtl/panel_pkg.sv
// panel_pkg: shared panel geometry, scanner states and pixel channel slicing
package panel_pkg;
  localparam int COLS = 48;
  localparam int ROWS = 48;
  localparam int SCAN = ROWS / 2;
  localparam int MEM_DEPTH = 2304;
  localparam int CH_R = 16;
  localparam int CH_G = 8;
  localparam int CH_B = 0;
  typedef enum logic [3:0] {
    IDLE, RD_TOP, RD_BOT, SH_LO, SH_HI, LATCH, ROWSET, DISPLAY, NEXT
  } state_e;
  function automatic logic chan_bit(logic [23:0] px, int ch, logic [2:0] p);
    return px[ch + int'(p)];
  endfunction
endpackage

// File: rtl/bcm_timer.sv
// bcm_timer: loadable down-counter giving the lit time of one bit-plane (PANEL_BRIGHTNESS_EN scales it)
module bcm_timer #(
  parameter int BASE_ON = 4,
  parameter int W = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] plane_i,
  input  logic       start_i,
`ifdef PANEL_BRIGHTNESS_EN
  input  logic [7:0] brightness_i,
`endif
  output logic       done_o
);
  logic [W-1:0] cnt_q, on_time;
`ifdef PANEL_BRIGHTNESS_EN
  assign on_time = W'((((W+8)'(BASE_ON) << plane_i) * (W+8)'(brightness_i)) >> 8);
`else
  assign on_time = W'(BASE_ON) << plane_i;
`endif
  // Loaded one cycle ahead of DISPLAY, so a zero on-time is already visible when the scanner decides to skip
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else if (start_i) cnt_q <= on_time;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/led_panel_scanner.sv
// led_panel_scanner: HUB75 BCM refresh controller on frame-memory port B (PANEL_BRIGHTNESS_EN adds brightness input)
module led_panel_scanner #(
  parameter int COLS = panel_pkg::COLS,
  parameter int ROWS = panel_pkg::ROWS,
  parameter int BASE_ON = 4,
  localparam int SCAN = ROWS / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [11:0] mem_addr,
  output logic        mem_re,
  input  logic [23:0] mem_dat,
  output logic        r0,
  output logic        g0,
  output logic        b0,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic [4:0]  row_addr,
  output logic        sclk,
  output logic        lat,
  output logic        oe_n,
  output logic        frame_done
`ifdef PANEL_BRIGHTNESS_EN
  ,
  input  logic [7:0]  brightness
`endif
);
  import panel_pkg::*;
  state_e state_q, state_d;
  logic [11:0] col_q, col_d, base_q, base_d, top_addr;
  logic [4:0] row_q, row_d, row_addr_q;
  logic [2:0] plane_q, plane_d;
  logic [23:0] top_q;
  logic [5:0] pix_q, pix_d;
  logic tmr_done;
  bcm_timer #(.BASE_ON(BASE_ON)) u_timer (
    .clk_i(clk),
    .rst_ni(rst),
    .plane_i(plane_q),
    .start_i(state_q == LATCH),
`ifdef PANEL_BRIGHTNESS_EN
    .brightness_i(brightness),
`endif
    .done_o(tmr_done)
  );
  assign top_addr = base_q + col_q;
  assign pix_d = {chan_bit(top_q, CH_R, plane_q), chan_bit(top_q, CH_G, plane_q), chan_bit(top_q, CH_B, plane_q),
                  chan_bit(mem_dat, CH_R, plane_q), chan_bit(mem_dat, CH_G, plane_q), chan_bit(mem_dat, CH_B, plane_q)};
  // State, scan counters and captured pixel/row data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      col_q <= '0;
      base_q <= '0;
      row_q <= '0;
      plane_q <= '0;
      top_q <= '0;
      pix_q <= '0;
      row_addr_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      base_q <= base_d;
      row_q <= row_d;
      plane_q <= plane_d;
      if (state_q == RD_BOT) top_q <= mem_dat;
      if (state_q == SH_LO) pix_q <= pix_d;
      if (state_q == ROWSET) row_addr_q <= row_q;
    end
  // Scan sequencing; enable is only consulted in IDLE and at the frame boundary
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    base_d = base_q;
    row_d = row_q;
    plane_d = plane_q;
    case (state_q)
      IDLE:    state_d = enable ? RD_TOP : IDLE;
      RD_TOP:  state_d = RD_BOT;
      RD_BOT:  state_d = SH_LO;
      SH_LO:   state_d = SH_HI;
      SH_HI: begin
        state_d = col_q == 12'(COLS - 1) ? LATCH : RD_TOP;
        col_d = col_q == 12'(COLS - 1) ? '0 : col_q + 1'b1;
      end
      LATCH:   state_d = ROWSET;
      ROWSET:  state_d = tmr_done ? NEXT : DISPLAY;
      DISPLAY: state_d = tmr_done ? NEXT : DISPLAY;
      NEXT: begin
        plane_d = plane_q + 1'b1;
        state_d = RD_TOP;
        if (plane_q == 3'd7) begin
          row_d = row_q == 5'(SCAN - 1) ? '0 : row_q + 1'b1;
          base_d = row_q == 5'(SCAN - 1) ? '0 : base_q + 12'(COLS);
          state_d = row_q == 5'(SCAN - 1) && !enable ? IDLE : RD_TOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign mem_re = state_q == RD_TOP || state_q == RD_BOT;
  assign mem_addr = state_q == RD_TOP ? top_addr : state_q == RD_BOT ? top_addr + 12'(SCAN * COLS) : '0;
  assign {r0, g0, b0, r1, g1, b1} = state_q == SH_LO ? pix_d : pix_q;
  assign sclk = state_q == SH_HI;
  assign lat = state_q == LATCH;
  assign row_addr = state_q == ROWSET ? row_q : row_addr_q;
  assign oe_n = state_q != DISPLAY;
  assign frame_done = state_q == NEXT && plane_q == 3'd7 && row_q == 5'(SCAN - 1);
endmodule
